// File: rtl/stream_mux_rr.sv
// N-channel stream multiplexer with valid/ready on every port, fixed-select or
// round-robin arbitration, and a one-entry registered output stage.
module stream_mux_rr #(
  parameter int N_CH  = 4,
  parameter int DW    = 8,
  parameter int SEL_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_CH*DW-1:0]   ip,
  input  logic [N_CH-1:0]      ip_valid,
  output logic [N_CH-1:0]      ip_ready,
  input  logic                 mode,
  input  logic [SEL_W-1:0]     sel,
  output logic [DW-1:0]        out,
  output logic                 out_valid,
  output logic [SEL_W-1:0]     out_ch,
  input  logic                 out_ready
);

  // Handshake: a word moves on any port at a rising clk edge where its valid
  // and ready are both 1. ip_ready depends on ip_valid, mode, sel and the
  // output stage state, never on ip data; producers must not gate valid on ready.

  logic [DW-1:0]    out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic [SEL_W-1:0] last_gnt_q, last_gnt_d;

  logic             load_en;
  logic             gnt_valid;
  logic [SEL_W-1:0] gnt;
  logic [DW-1:0]    gnt_data;
  logic             xfer;

  // The output register can take a new word in the same cycle it drains.
  assign load_en = !out_valid_q || out_ready;

  // Grant selection.
  always_comb begin
    int unsigned idx;
    gnt_valid = 1'b0;
    gnt       = '0;
    idx       = 0;
    if (!mode) begin
      if (int'(sel) < N_CH) begin
        if (ip_valid[sel]) begin
          gnt_valid = 1'b1;
          gnt       = sel;
        end
      end
    end else begin
      // Scan upward from the channel after the last round-robin winner.
      for (int i = 1; i <= N_CH; i++) begin
        idx = (int'(last_gnt_q) + i) % N_CH;
        if (!gnt_valid && ip_valid[idx]) begin
          gnt_valid = 1'b1;
          gnt       = idx[SEL_W-1:0];
        end
      end
    end
  end

  // Data mux on constant slices keeps the selection free of out-of-range reads.
  always_comb begin
    gnt_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (gnt == SEL_W'(k)) gnt_data = ip[k*DW +: DW];
    end
  end

  always_comb begin
    ip_ready = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (gnt_valid && gnt == SEL_W'(k)) ip_ready[k] = load_en && rst_n;
    end
  end

  assign xfer = gnt_valid && load_en;

  always_comb begin
    out_d       = out_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    last_gnt_d  = last_gnt_q;
    if (load_en) begin
      if (xfer) begin
        out_d       = gnt_data;
        out_ch_d    = gnt;
        out_valid_d = 1'b1;
        if (mode) last_gnt_d = gnt;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      last_gnt_q  <= SEL_W'(N_CH - 1);
    end else begin
      out_q       <= out_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      last_gnt_q  <= last_gnt_d;
    end
  end

  assign out       = out_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
Parametrised N-channel registered stream multiplexer. It supersedes the fixed 4-to-1 combinational mux and adds three things: a valid/ready handshake on every input and on the output, a selectable fixed-select or round-robin arbitration mode, and a one-entry registered output stage. It sits between multiple producer channels and a single consumer, such as a shared bus or a serialiser.

Parameters:
N_CH, 4, number of input channels (2..16).
DW, 8, data width per channel in bits.
SEL_W, 2, width of sel/out_ch; must equal ceil(log2(N_CH)).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
ip  input  N_CH*DW  packed channel data; channel k occupies ip[k*DW +: DW].
ip_valid  input  N_CH  per-channel data-valid.
ip_ready  output  N_CH  per-channel accept (combinational).
mode  input  1  0 = fixed select via sel; 1 = round-robin.
sel  input  SEL_W  channel index used when mode=0.
out  output  DW  registered output data.
out_valid  output  1  out holds a valid word.
out_ch  output  SEL_W  index of the channel that sourced out.
out_ready  input  1  consumer accept.

Behaviour:
- Reset (async assert, sync release):
  - out=0, out_valid=0, out_ch=0.
  - Round-robin pointer last_gnt=N_CH-1, so the first RR search starts at channel 0.
  - ip_ready=0 while rst_n=0.
- Transfer: a transfer on any port occurs on a rising clk edge where valid=1 and ready=1.
- Load enable: load_en = !out_valid | out_ready. The output register accepts a new word in the same cycle the held word drains, giving full throughput of 1 word/clk.
- Grant (combinational, evaluated every cycle):
  - mode=0: gnt=sel if sel<N_CH and ip_valid[sel]=1; otherwise no grant. Other channels are never granted, even if valid.
  - mode=1: gnt is the first k with ip_valid[k]=1, scanning (last_gnt+1) mod N_CH upward with wrap-around. If no channel is valid, no grant.
- Handshake:
  - ip_ready[gnt]=load_en; all other ip_ready bits=0.
  - ip_ready never depends combinationally on ip_data.
  - ip_ready may depend on ip_valid; producers must not make valid depend on ready.
- On an input transfer: out<=ip[gnt], out_ch<=gnt, out_valid<=1. In mode=1, last_gnt<=gnt.
- No grant with load_en=1: out_valid<=0 and out/out_ch hold their old values.
- out_valid=1 and out_ready=0: out, out_ch and out_valid hold stable, and all ip_ready=0.
- Latency: exactly 1 clk from input transfer to out_valid.
- last_gnt updates only on transfers in mode=1. A mode=0 transfer leaves it unchanged, so RR resumes from the prior position.
- Mode or sel change mid-stream: affects only the next grant. A word already in the output register is unaffected.
- Single valid channel in RR: that channel is granted every cycle (no bubbles).
- sel>=N_CH (non-power-of-2 N_CH): no grant, no transfer, no X propagation.
- Reset asserted mid-operation: the held word is discarded and out_valid drops immediately (asynchronously).
- Producers must hold ip/ip_valid stable while valid=1 and ready=0. Violations are the producer's error; the block still grants per the current cycle's values.

Test Plan:
1. Reset, then mode=0, sel=1, ip=0x44_33_22_11, ip_valid=4'b0010, out_ready=1 -> ip_ready=4'b0010; next clk out=0x22, out_ch=1, out_valid=1.
2. mode=1, all four channels valid continuously, channel k data=0xA0+k, out_ready=1 -> out sequence 0xA0,0xA1,0xA2,0xA3,0xA0 on consecutive clks, out_ch 0,1,2,3,0.
3. Backpressure: mode=1, out_ready=0 for 3 clks after first word -> out/out_ch frozen and ip_ready=0 for those 3 clks. Then out_ready=1 -> the next word follows with no loss and no duplication.
4. RR fairness with sparse valid: ip_valid=4'b1001, mode=1 -> grants alternate 0,3,0,3. Then drop ip_valid[0] -> channel 3 is granted every clk.
5. mode=0, sel=2, ip_valid[2]=0, others valid -> no ip_ready asserted; out_valid falls to 0 after the held word drains.
6. Assert rst_n=0 mid-burst with out_valid=1 -> out_valid=0 and out=0 immediately. After release, the RR search restarts from channel 0.
